// File: rtl/parity_pkg.sv
// Shared definitions for the serial parity checker: FSM state encoding and
// error-counter sizing.
package parity_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2
    } state_t;

    localparam int unsigned           ERR_W   = 8;
    localparam logic [ERR_W-1:0]      ERR_MAX = 8'd255;

endpackage

// File: rtl/XORgate3.sv
// Three-input XOR cell used as the parity datapath.
module XORgate3 (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic y
);

    assign y = a ^ b ^ c;

endmodule

// File: rtl/serial_parity_checker.sv
// Deserialises DATA_BITS data bits plus one parity bit per frame (LSB first),
// flags parity errors and keeps a saturating count of failed frames.
module serial_parity_checker
    import parity_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int ODD_PARITY = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 din,
    input  logic                 din_valid,
    input  logic                 sof,
    output logic                 busy,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 done,
    output logic                 perr,
    output logic [ERR_W-1:0]     err_count
);

    localparam int unsigned CNT_W   = $clog2(DATA_BITS) + 1;
    localparam logic        ODD_BIT = (ODD_PARITY != 0);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_BITS - 1);

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 acc_q, acc_d;
    logic [DATA_BITS-1:0] sr_q, sr_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 perr_q, perr_d;
    logic                 done_q, done_d;
    logic                 busy_q, busy_d;
    logic [ERR_W-1:0]     err_cnt_q, err_cnt_d;
    logic                 par_err;

    XORgate3 u_xor3 (
        .a (acc_q),
        .b (din),
        .c (ODD_BIT),
        .y (par_err)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        sr_d      = sr_q;
        data_d    = data_q;
        perr_d    = perr_q;
        done_d    = 1'b0;
        err_cnt_d = err_cnt_q;

        if (din_valid) begin
            // sof restarts a frame from any state, discarding partial data
            if (sof) begin
                sr_d    = {din, sr_q[DATA_BITS-1:1]};
                acc_d   = din;
                cnt_d   = CNT_W'(1);
                state_d = ST_DATA;
            end else begin
                unique case (state_q)
                    ST_DATA: begin
                        sr_d  = {din, sr_q[DATA_BITS-1:1]};
                        acc_d = acc_q ^ din;
                        cnt_d = cnt_q + CNT_W'(1);
                        if (cnt_q == LAST_IDX) begin
                            state_d = ST_PARITY;
                        end
                    end
                    ST_PARITY: begin
                        data_d  = sr_q;
                        perr_d  = par_err;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                        if (par_err && (err_cnt_q != ERR_MAX)) begin
                            err_cnt_d = err_cnt_q + ERR_W'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            acc_q     <= 1'b0;
            sr_q      <= '0;
            data_q    <= '0;
            perr_q    <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            sr_q      <= sr_d;
            data_q    <= data_d;
            perr_q    <= perr_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign busy      = busy_q;
    assign data_out  = data_q;
    assign done      = done_q;
    assign perr      = perr_q;
    assign err_count = err_cnt_q;

endmodule

// File: tb/tb_serial_parity_checker.sv
// Bench for serial_parity_checker: an even-parity and an odd-parity instance
// driven by directed and random bit streams, checked against a frame model.
module tb_serial_parity_checker;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       din = 1'b0;
    logic       sof = 1'b0;
    logic       v_e = 1'b0;
    logic       v_o = 1'b0;

    logic       busy_e, done_e, perr_e;
    logic [7:0] data_e, ec_e;
    logic       busy_o, done_o, perr_o;
    logic [7:0] data_o, ec_o;

    int n_vec = 0;
    int n_err = 0;

    // Model: frame progress per instance (0 = no frame open), collected word,
    // and the expected registered outputs.
    int         nb    [2] = '{0, 0};
    logic [7:0] word  [2] = '{8'h00, 8'h00};
    logic [7:0] m_data[2] = '{8'h00, 8'h00};
    logic       m_perr[2] = '{1'b0, 1'b0};
    logic       m_done[2] = '{1'b0, 1'b0};
    int         m_cnt [2] = '{0, 0};

    serial_parity_checker #(.DATA_BITS(8), .ODD_PARITY(0)) dut_e (
        .clk(clk), .rst(rst), .din(din), .din_valid(v_e), .sof(sof),
        .busy(busy_e), .data_out(data_e), .done(done_e), .perr(perr_e),
        .err_count(ec_e)
    );

    serial_parity_checker #(.DATA_BITS(8), .ODD_PARITY(1)) dut_o (
        .clk(clk), .rst(rst), .din(din), .din_valid(v_o), .sof(sof),
        .busy(busy_o), .data_out(data_o), .done(done_o), .perr(perr_o),
        .err_count(ec_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_bit(input int i, input logic b, input logic s);
        logic odd;
        logic err;
        odd = (i == 1);
        if (s) begin
            nb[i]   = 1;
            word[i] = {7'b0, b};
        end else if (nb[i] >= 1 && nb[i] < 8) begin
            word[i][nb[i]] = b;
            nb[i]++;
        end else if (nb[i] == 8) begin
            err       = ((($countones(word[i]) + int'(b)) % 2) == 1) != odd;
            m_data[i] = word[i];
            m_perr[i] = err;
            m_done[i] = 1'b1;
            if (err && m_cnt[i] < 255) m_cnt[i]++;
            nb[i] = 0;
        end
    endtask

    task automatic check_all();
        chk("e.busy", busy_e, nb[0] > 0);
        chk("e.done", done_e, m_done[0]);
        chk("e.data", data_e, m_data[0]);
        chk("e.perr", perr_e, m_perr[0]);
        chk("e.errc", ec_e,   m_cnt[0]);
        chk("o.busy", busy_o, nb[1] > 0);
        chk("o.done", done_o, m_done[1]);
        chk("o.data", data_o, m_data[1]);
        chk("o.perr", perr_o, m_perr[1]);
        chk("o.errc", ec_o,   m_cnt[1]);
    endtask

    task automatic step(input logic ve, input logic vo, input logic d,
                        input logic s, input logic r);
        @(negedge clk);
        v_e = ve; v_o = vo; din = d; sof = s; rst = r;
        @(posedge clk);
        for (int unsigned i = 0; i < 2; i++) begin
            m_done[i] = 1'b0;
            if (r) begin
                nb[i] = 0; word[i] = '0; m_data[i] = '0;
                m_perr[i] = 1'b0; m_cnt[i] = 0;
            end else if ((i == 0) ? ve : vo) begin
                model_bit(int'(i), d, s);
            end
        end
        #1 check_all();
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned k = 0; k < n; k++)
            step(1'b0, 1'b0, 1'($urandom), 1'($urandom), 1'b0);
    endtask

    task automatic send_frame(input int inst, input logic [7:0] w, input logic p,
                              input int unsigned gap);
        logic b;
        for (int unsigned k = 0; k < 9; k++) begin
            b = (k < 8) ? w[k] : p;
            step(inst == 0, inst == 1, b, k == 0, 1'b0);
            if (k < 8) idle(gap);
        end
    endtask

    initial begin
        // Reset with din_valid toggling
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        chk("rst_busy", busy_e, 1'b0);
        chk("rst_errc", ec_e, 8'd0);
        // Bits without sof are ignored after reset
        for (int unsigned k = 0; k < 4; k++) step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("nosof_done", done_e, 1'b0);

        send_frame(0, 8'hA5, 1'b0, 0);
        chk("a5_done", done_e, 1'b1);
        chk("a5_data", data_e, 8'hA5);
        chk("a5_perr", perr_e, 1'b0);
        idle(1);
        chk("a5_busy_after", busy_e, 1'b0);

        send_frame(0, 8'h07, 1'b0, 0);
        chk("07_perr", perr_e, 1'b1);
        chk("07_errc", ec_e, 8'd1);
        idle(2);
        send_frame(0, 8'h3C, 1'b0, 3);
        chk("3c_data", data_e, 8'h3C);
        chk("3c_perr", perr_e, 1'b0);
        chk("3c_errc", ec_e, 8'd1);

        // Aborted partial frame, then a full frame, then one back-to-back
        for (int unsigned k = 0; k < 5; k++) step(1'b1, 1'b0, 1'b1, k == 0, 1'b0);
        send_frame(0, 8'h81, 1'b0, 0);
        chk("81_data", data_e, 8'h81);
        send_frame(0, 8'hFF, 1'b0, 0);
        chk("ff_data", data_e, 8'hFF);
        chk("ff_perr", perr_e, 1'b0);

        // Reset mid-frame, then stray bits without sof
        for (int unsigned k = 0; k < 4; k++) step(1'b1, 1'b0, 1'b0, k == 0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        for (int unsigned k = 0; k < 5; k++) step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("midrst_busy", busy_e, 1'b0);
        chk("midrst_errc", ec_e, 8'd0);

        // Odd-parity instance
        send_frame(1, 8'h00, 1'b1, 0);
        chk("odd_ok_perr", perr_o, 1'b0);
        send_frame(1, 8'h00, 1'b0, 0);
        chk("odd_bad_perr", perr_o, 1'b1);
        for (int unsigned f = 0; f < 256; f++) send_frame(1, 8'h00, 1'b0, 0);
        chk("sat_errc", ec_o, 8'd255);
        send_frame(1, 8'h01, 1'b1, 0);
        chk("sat_hold", ec_o, 8'd255);

        // Random streams on both instances
        for (int unsigned k = 0; k < 4000; k++) begin
            if ($urandom_range(0, 299) == 0)
                step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            else
                step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                     1'($urandom), $urandom_range(0, 11) == 0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
